// File: rtl/throw_pkg.sv
// Shared types for the throw path: FSM state encoding and power-meter width.
// throw_ctl imports this as well so both blocks agree on the width of power.
package throw_pkg;
    localparam int POWER_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        CHARGE,
        FIRE,
        FLIGHT
    } throw_state_t;
endpackage

// File: rtl/throw_trigger_if.sv
// Button-in / throw-out bundle between the input stage, throw_trigger and throw_ctl.
interface throw_trigger_if;
    import throw_pkg::*;

    logic               fire_btn;
    logic               enable;
    logic [POWER_W-1:0] power;
    logic [POWER_W-1:0] power_meter;
    logic               busy;

    modport master (
        input  fire_btn,
        output enable,
        output power,
        output power_meter,
        output busy
    );

    modport slave (
        output fire_btn,
        input  enable,
        input  power,
        input  power_meter,
        input  busy
    );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer.
// The debounced level resets to "pressed" so a button held through reset never looks like a fresh press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 65_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = CNT_LOAD;
        // Down-counter runs only while the synced level disagrees; any agreeing sample reloads it.
        if (sync2_q != db_q) begin
            if (cnt_q == '0) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b1;
            cnt_q   <= CNT_LOAD;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_db = db_q;
endmodule

// File: rtl/throw_trigger.sv
// Charged-throw trigger: hold to ramp power, release to fire a one-cycle enable,
// then lock out new throws until the flight time has elapsed.
module throw_trigger
    import throw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65_000,
    parameter int CHARGE_DIV      = 650_000,
    parameter int POWER_MAX       = 100,
    parameter int POWER_MIN       = 1,
    parameter int FLIGHT_CYCLES   = 6400
) (
    input  logic            clk,
    input  logic            rst,
    throw_trigger_if.master bus
);
    localparam int DIV_W = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
    localparam int FLT_W = (FLIGHT_CYCLES > 1) ? $clog2(FLIGHT_CYCLES) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CHARGE_DIV - 1);
    localparam logic [FLT_W-1:0]   FLT_LAST = FLT_W'(FLIGHT_CYCLES - 1);
    localparam logic [POWER_W-1:0] P_MAX    = POWER_W'(POWER_MAX);
    localparam logic [POWER_W-1:0] P_MIN    = POWER_W'(POWER_MIN);

    logic btn_db;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(bus.fire_btn),
        .btn_db (btn_db)
    );

    throw_state_t       state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [FLT_W-1:0]   flight_q, flight_d;
    logic [POWER_W-1:0] meter_q, meter_d;
    logic [POWER_W-1:0] power_q, power_d;
    logic               enable_q, enable_d;
    logic               prev_q, prev_d;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        flight_d = flight_q;
        meter_d  = meter_q;
        power_d  = power_q;
        enable_d = 1'b0;
        prev_d   = btn_db;
        unique case (state_q)
            IDLE: begin
                if (btn_db && !prev_q) begin
                    state_d = CHARGE;
                    div_d   = '0;
                    meter_d = '0;
                end
            end
            CHARGE: begin
                if (!btn_db) begin
                    div_d   = '0;
                    meter_d = '0;
                    if (meter_q >= P_MIN) begin
                        state_d  = FIRE;
                        power_d  = meter_q;
                        enable_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    meter_d = (meter_q >= P_MAX) ? P_MAX : meter_q + 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            FIRE: begin
                state_d  = FLIGHT;
                meter_d  = '0;
                flight_d = '0;
            end
            FLIGHT: begin
                if (flight_q == FLT_LAST) begin
                    state_d = IDLE;
                end else begin
                    flight_d = flight_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // prev resets high to match the debouncer's "pressed" reset level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            flight_q <= '0;
            meter_q  <= '0;
            power_q  <= '0;
            enable_q <= 1'b0;
            prev_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            flight_q <= flight_d;
            meter_q  <= meter_d;
            power_q  <= power_d;
            enable_q <= enable_d;
            prev_q   <= prev_d;
        end
    end

    assign bus.enable      = enable_q;
    assign bus.power       = power_q;
    assign bus.power_meter = meter_q;
    assign bus.busy        = (state_q != IDLE);
endmodule
